// File: rtl/vga_out_pkg.sv
// vga_out_pkg: shared types and default timing constants for the LX45 VGA output stage.
package vga_out_pkg;

  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int H_NOMINAL         = 192;
  localparam int H_MIN_DEF         = H_NOMINAL - 4;
  localparam int H_MAX_DEF         = H_NOMINAL + 4;
  localparam int V_MIN_DEF         = 200;
  localparam int V_MAX_DEF         = 600;
  localparam int LOCK_FRAMES_DEF   = 4;
  localparam int UNLOCK_FRAMES_DEF = 2;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } lockState_t;

endpackage

// File: rtl/sync_lock_fsm.sv
// sync_lock_fsm: measures line/frame timing from the stage-1 syncs and decides
// whether the incoming video is stable enough to be shown.
module sync_lock_fsm
  import vga_out_pkg::*;
#(
  parameter int H_MIN         = H_MIN_DEF,
  parameter int H_MAX         = H_MAX_DEF,
  parameter int V_MIN         = V_MIN_DEF,
  parameter int V_MAX         = V_MAX_DEF,
  parameter int LOCK_FRAMES   = LOCK_FRAMES_DEF,
  parameter int UNLOCK_FRAMES = UNLOCK_FRAMES_DEF
) (
  input  logic             i_clk,
  input  logic             i_rstN,
  input  logic             i_hsS1,
  input  logic             i_vsS1,
  output logic             o_locked,
  output logic [CNT_W-1:0] o_hperiod,
  output logic [CNT_W-1:0] o_vlines
);

  // Frame counters are 4 bits wide, so lock/unlock thresholds up to 15 are supported.
  localparam int FCNT_W = 4;
  localparam logic [CNT_W-1:0]  H_MIN_C    = CNT_W'(H_MIN);
  localparam logic [CNT_W-1:0]  H_MAX_C    = CNT_W'(H_MAX);
  localparam logic [CNT_W-1:0]  V_MIN_C    = CNT_W'(V_MIN);
  localparam logic [CNT_W-1:0]  V_MAX_C    = CNT_W'(V_MAX);
  localparam logic [FCNT_W-1:0] LOCK_C     = FCNT_W'(LOCK_FRAMES);
  localparam logic [FCNT_W-1:0] UNLOCK_C   = FCNT_W'(UNLOCK_FRAMES);
  localparam logic [FCNT_W-1:0] FCNT_ONE   = FCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  logic              r_hsS2;
  logic              r_vsS2;
  logic [CNT_W-1:0]  r_hc;
  logic [CNT_W-1:0]  r_vc;
  logic              r_lineBad;
  logic [FCNT_W-1:0] r_goodCnt;
  logic [FCNT_W-1:0] r_badCnt;
  lockState_t        r_state;

  logic              w_hFall;
  logic              w_vFall;
  logic              w_hMiss;
  logic              w_frameGood;
  logic              w_timeout;
  lockState_t        w_stateNext;
  logic [FCNT_W-1:0] w_goodNext;
  logic [FCNT_W-1:0] w_badNext;
  logic              w_lockedNext;

  assign w_hFall = !i_hsS1 && r_hsS2;
  assign w_vFall = !i_vsS1 && r_vsS2;
  assign w_hMiss = (r_hc < H_MIN_C) || (r_hc > H_MAX_C);

  // The line ending on a coincident hsync/vsync fall still belongs to the frame being closed.
  assign w_frameGood = !(r_lineBad || (w_hFall && w_hMiss)) &&
                       (r_vc >= V_MIN_C) && (r_vc <= V_MAX_C);

  // A saturated line counter that is just being reloaded by an hsync fall is a long line, not a lost signal.
  assign w_timeout = (r_hc == CNT_MAX) && !w_hFall;

  // Stage-2 copies of the syncs, used only to find falling edges.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_hsS2 <= 1'b1;
      r_vsS2 <= 1'b1;
    end else begin
      r_hsS2 <= i_hsS1;
      r_vsS2 <= i_vsS1;
    end
  end

  // Line length counter; hperiod saturates rather than wrapping after a dead line.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_hc      <= '0;
      o_hperiod <= '0;
    end else if (w_hFall) begin
      r_hc      <= '0;
      o_hperiod <= (r_hc == CNT_MAX) ? CNT_MAX : r_hc + CNT_ONE;
    end else if (r_hc != CNT_MAX) begin
      r_hc <= r_hc + CNT_ONE;
    end
  end

  // Lines-per-frame counter and the sticky bad-line flag for the current frame.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_vc      <= '0;
      r_lineBad <= 1'b0;
      o_vlines  <= '0;
    end else if (w_vFall) begin
      o_vlines  <= r_vc;
      r_vc      <= w_hFall ? CNT_ONE : '0;
      r_lineBad <= 1'b0;
    end else if (w_hFall) begin
      if (r_vc != CNT_MAX) begin
        r_vc <= r_vc + CNT_ONE;
      end
      if (w_hMiss) begin
        r_lineBad <= 1'b1;
      end
    end
  end

  // Lock FSM state, frame counters and the registered lock flag.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_state   <= SEARCH;
      r_goodCnt <= '0;
      r_badCnt  <= '0;
      o_locked  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_goodCnt <= w_goodNext;
      r_badCnt  <= w_badNext;
      o_locked  <= w_lockedNext;
    end
  end

  // Next-state logic: lock after enough good frames, drop after enough bad ones, bail out on a dead line.
  always_comb begin
    w_stateNext  = r_state;
    w_goodNext   = r_goodCnt;
    w_badNext    = r_badCnt;
    w_lockedNext = o_locked;
    case (r_state)
      SEARCH: begin
        w_goodNext   = '0;
        w_badNext    = '0;
        w_lockedNext = 1'b0;
        if (w_vFall) begin
          w_stateNext = MEASURE;
        end
      end
      MEASURE: begin
        if (w_vFall) begin
          if (!w_frameGood) begin
            w_goodNext = '0;
          end else if ((r_goodCnt + FCNT_ONE) == LOCK_C) begin
            w_stateNext  = LOCKED;
            w_lockedNext = 1'b1;
            w_goodNext   = '0;
          end else begin
            w_goodNext = r_goodCnt + FCNT_ONE;
          end
        end
      end
      LOCKED: begin
        if (w_vFall) begin
          if (w_frameGood) begin
            w_badNext = '0;
          end else if ((r_badCnt + FCNT_ONE) == UNLOCK_C) begin
            w_stateNext  = SEARCH;
            w_lockedNext = 1'b0;
            w_badNext    = '0;
          end else begin
            w_badNext = r_badCnt + FCNT_ONE;
          end
        end
      end
      default: begin
        w_stateNext  = SEARCH;
        w_lockedNext = 1'b0;
      end
    endcase
    if (w_timeout) begin
      w_stateNext  = SEARCH;
      w_lockedNext = 1'b0;
      w_goodNext   = '0;
      w_badNext    = '0;
    end
  end

endmodule

// File: rtl/vga_output_lx45.sv
// vga_output_lx45: two-stage output pipe from the scan converter to the VGA connector,
// with sync polarity, 3-3-2 to 4-4-4 colour expansion and lock-gated colour.
module vga_output_lx45
  import vga_out_pkg::*;
#(
  parameter int H_MIN         = H_MIN_DEF,
  parameter int H_MAX         = H_MAX_DEF,
  parameter int V_MIN         = V_MIN_DEF,
  parameter int V_MAX         = V_MAX_DEF,
  parameter int LOCK_FRAMES   = LOCK_FRAMES_DEF,
  parameter int UNLOCK_FRAMES = UNLOCK_FRAMES_DEF,
  parameter bit HS_POL        = 1'b0,
  parameter bit VS_POL        = 1'b0
) (
  input  logic             clk6m,
  input  logic             reset_n,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic             blank_i,
  input  logic [7:0]       rgb_i,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             locked,
  output logic [CNT_W-1:0] hperiod,
  output logic [CNT_W-1:0] vlines
);

  logic       r_hsS1;
  logic       r_vsS1;
  logic       r_blankS1;
  logic [7:0] r_rgbS1;
  logic       w_colourOn;

  // Colour is shown only on active pixels once the timing is trusted.
  assign w_colourOn = !r_blankS1 && locked;

  // Stage 1: capture everything from the scan converter on the same edge.
  always_ff @(posedge clk6m or negedge reset_n) begin
    if (!reset_n) begin
      r_hsS1    <= 1'b1;
      r_vsS1    <= 1'b1;
      r_blankS1 <= 1'b1;
      r_rgbS1   <= '0;
    end else begin
      r_hsS1    <= hsync_i;
      r_vsS1    <= vsync_i;
      r_blankS1 <= blank_i;
      r_rgbS1   <= rgb_i;
    end
  end

  // Stage 2: drive the pins; syncs always pass, colour is expanded by repeating its top bits.
  always_ff @(posedge clk6m or negedge reset_n) begin
    if (!reset_n) begin
      vga_hs <= HS_POL;
      vga_vs <= VS_POL;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      vga_hs <= r_hsS1 ^ HS_POL;
      vga_vs <= r_vsS1 ^ VS_POL;
      vga_r  <= w_colourOn ? {r_rgbS1[7:5], r_rgbS1[7]} : 4'h0;
      vga_g  <= w_colourOn ? {r_rgbS1[4:2], r_rgbS1[4]} : 4'h0;
      vga_b  <= w_colourOn ? {r_rgbS1[1:0], r_rgbS1[1:0]} : 4'h0;
    end
  end

  sync_lock_fsm #(
    .H_MIN        (H_MIN),
    .H_MAX        (H_MAX),
    .V_MIN        (V_MIN),
    .V_MAX        (V_MAX),
    .LOCK_FRAMES  (LOCK_FRAMES),
    .UNLOCK_FRAMES(UNLOCK_FRAMES)
  ) u_syncLock (
    .i_clk    (clk6m),
    .i_rstN   (reset_n),
    .i_hsS1   (r_hsS1),
    .i_vsS1   (r_vsS1),
    .o_locked (locked),
    .o_hperiod(hperiod),
    .o_vlines (vlines)
  );

endmodule

// File: tb/tb_vga_output_lx45.sv
// tb_vga_output_lx45: directed checks of lock acquisition, pipeline alignment,
// colour expansion, blanking, hysteresis and timeout.
module tb_vga_output_lx45;

  // Short frames keep the run small; V bounds are scaled to match.
  localparam int FRAME_LINES = 8;

  logic        clk6m = 1'b0;
  logic        reset_n;
  logic        hsync_i;
  logic        vsync_i;
  logic        blank_i;
  logic [7:0]  rgb_i;
  logic        vga_hs;
  logic        vga_vs;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        locked;
  logic [10:0] hperiod;
  logic [10:0] vlines;

  int          checkCount = 0;
  int          passCount  = 0;
  int          frameNo;
  int          curLn;
  int          curPx;
  int          holdClks;
  int          lineLen;
  bit          gShort = 1'b0;
  bit          gHold  = 1'b0;
  logic [7:0]  gRgb   = 8'h00;
  int          baseB;
  int          baseA;
  int          baseR;

  vga_output_lx45 #(
    .V_MIN (6),
    .V_MAX (12),
    .HS_POL(1'b1),
    .VS_POL(1'b0)
  ) dut (
    .clk6m  (clk6m),
    .reset_n(reset_n),
    .hsync_i(hsync_i),
    .vsync_i(vsync_i),
    .blank_i(blank_i),
    .rgb_i  (rgb_i),
    .vga_hs (vga_hs),
    .vga_vs (vga_vs),
    .vga_r  (vga_r),
    .vga_g  (vga_g),
    .vga_b  (vga_b),
    .locked (locked),
    .hperiod(hperiod),
    .vlines (vlines)
  );

  always #10 clk6m = ~clk6m;

  // Compare one observed value against its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Set the generator controls: colour value, short-line injection, sync hold.
  task automatic applyStimulus(input logic [7:0] rgb, input bit shortLine, input bit hold);
    gRgb   = rgb;
    gShort = shortLine;
    gHold  = hold;
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk6m);
  endtask

  task automatic waitFrame(input int target);
    int n;
    n = 0;
    while (frameNo < target && n < 12000) begin
      @(negedge clk6m);
      n++;
    end
    if (frameNo < target) checkOutput("waitFrame", 0, 1);
  endtask

  task automatic waitPos(input int ln, input int px);
    int n;
    n = 0;
    while (!(curLn == ln && curPx == px) && n < 5000) begin
      @(negedge clk6m);
      n++;
    end
    if (!(curLn == ln && curPx == px)) checkOutput("waitPos", 0, 1);
  endtask

  task automatic waitHold(input int clks);
    int n;
    n = 0;
    while (holdClks < clks && n < 4000) begin
      @(negedge clk6m);
      n++;
    end
    if (holdClks < clks) checkOutput("waitHold", 0, 1);
  endtask

  // Video source: 192-clock lines, hsync low 23 clocks, vsync/blank on lines 0-1,
  // blank for the first 40 clocks of every line; line 5 shrinks to 150 on request.
  initial begin : generator
    hsync_i  = 1'b1;
    vsync_i  = 1'b1;
    blank_i  = 1'b1;
    rgb_i    = 8'h00;
    frameNo  = 0;
    curLn    = 0;
    curPx    = 0;
    holdClks = 0;
    lineLen  = 192;
    wait (reset_n === 1'b1);
    forever begin
      if (gHold) begin
        @(posedge clk6m);
        #1;
        hsync_i = 1'b1;
        vsync_i = 1'b1;
        blank_i = 1'b1;
        holdClks++;
      end else begin
        frameNo++;
        holdClks = 0;
        for (int ln = 0; ln < FRAME_LINES; ln++) begin
          if (!gHold) begin
            lineLen = (gShort && ln == 5) ? 150 : 192;
            for (int px = 0; px < lineLen; px++) begin
              @(posedge clk6m);
              #1;
              hsync_i = (px < 23) ? 1'b0 : 1'b1;
              vsync_i = (ln < 2) ? 1'b0 : 1'b1;
              blank_i = (ln < 2) || (px < 40);
              rgb_i   = gRgb;
              curLn   = ln;
              curPx   = px;
            end
          end
        end
      end
    end
  end

  initial begin : main
    reset_n = 1'b0;
    #25;
    reset_n = 1'b1;

    // Stream running, not yet locked: measurements are live.
    waitFrame(3);
    waitPos(4, 50);
    checkOutput("preHperiod", 32'(hperiod), 32'd192);
    checkOutput("preVlines", 32'(vlines), 32'd8);
    checkOutput("preLocked", 32'(locked), 32'd0);

    // Asynchronous reset mid-line, checked before any clock edge.
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("rstHs", 32'(vga_hs), 32'd1);
    checkOutput("rstVs", 32'(vga_vs), 32'd0);
    checkOutput("rstR", 32'(vga_r), 32'd0);
    checkOutput("rstG", 32'(vga_g), 32'd0);
    checkOutput("rstB", 32'(vga_b), 32'd0);
    checkOutput("rstLocked", 32'(locked), 32'd0);
    checkOutput("rstHperiod", 32'(hperiod), 32'd0);
    checkOutput("rstVlines", 32'(vlines), 32'd0);
    @(negedge clk6m);
    #3;
    reset_n = 1'b1;

    // First vsync fall opens MEASURE; lock lands on the 4th good-frame vsync fall.
    baseB = frameNo + 1;
    waitFrame(baseB + 3);
    waitClocks(4);
    checkOutput("lockEarly", 32'(locked), 32'd0);
    waitFrame(baseB + 4);
    checkOutput("lockEdgeM0", 32'(locked), 32'd0);
    waitClocks(2);
    checkOutput("lockEdgeM2", 32'(locked), 32'd0);
    waitClocks(1);
    checkOutput("lockEdge", 32'(locked), 32'd1);
    waitPos(1, 10);
    checkOutput("nomHperiod", 32'(hperiod), 32'd192);
    checkOutput("nomVlines", 32'(vlines), 32'd8);

    // Colour expansion and 2-clock alignment with inverted hsync.
    applyStimulus(8'b101_110_01, 1'b0, 1'b0);
    waitPos(3, 1);
    checkOutput("hsPrevLine", 32'(vga_hs), 32'd0);
    waitPos(3, 2);
    checkOutput("hsFallLat", 32'(vga_hs), 32'd1);
    waitPos(3, 24);
    checkOutput("hsLowEnd", 32'(vga_hs), 32'd1);
    waitPos(3, 25);
    checkOutput("hsRiseLat", 32'(vga_hs), 32'd0);
    waitPos(3, 41);
    checkOutput("rBlankEdge", 32'(vga_r), 32'd0);
    waitPos(3, 42);
    checkOutput("rExpand", 32'(vga_r), 32'b1011);
    waitPos(3, 100);
    checkOutput("gExpand", 32'(vga_g), 32'b1101);
    checkOutput("bExpand", 32'(vga_b), 32'b0101);
    checkOutput("vsIdle", 32'(vga_vs), 32'd1);

    // Blanked white: colour stays 0 while syncs keep moving.
    applyStimulus(8'hFF, 1'b0, 1'b0);
    waitFrame(frameNo + 1);
    waitPos(0, 10);
    checkOutput("blankHsLow", 32'(vga_hs), 32'd1);
    checkOutput("blankVsLow", 32'(vga_vs), 32'd0);
    waitPos(0, 100);
    checkOutput("blankHsHigh", 32'(vga_hs), 32'd0);
    checkOutput("blankR", 32'(vga_r), 32'd0);
    checkOutput("blankG", 32'(vga_g), 32'd0);
    checkOutput("blankB", 32'(vga_b), 32'd0);
    waitPos(4, 100);
    checkOutput("whiteR", 32'(vga_r), 32'hF);
    checkOutput("whiteB", 32'(vga_b), 32'hF);

    // Hysteresis: one bad frame is tolerated, two in a row drop lock.
    baseA = frameNo + 1;
    waitFrame(baseA);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    waitPos(6, 10);
    checkOutput("shortHperiod", 32'(hperiod), 32'd150);
    applyStimulus(8'hFF, 1'b0, 1'b0);
    waitFrame(baseA + 1);
    waitClocks(4);
    checkOutput("oneBadKeep", 32'(locked), 32'd1);
    waitFrame(baseA + 2);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    waitFrame(baseA + 3);
    waitClocks(4);
    checkOutput("firstOfTwo", 32'(locked), 32'd1);
    waitFrame(baseA + 4);
    applyStimulus(8'hFF, 1'b0, 1'b0);
    waitClocks(4);
    checkOutput("twoBadDrop", 32'(locked), 32'd0);
    waitPos(4, 100);
    checkOutput("unlockedR", 32'(vga_r), 32'd0);
    checkOutput("unlockedVlines", 32'(vlines), 32'd8);

    // Relock after hysteresis drop.
    waitFrame(baseA + 8);
    waitClocks(4);
    checkOutput("relockEarly", 32'(locked), 32'd0);
    waitFrame(baseA + 9);
    waitClocks(4);
    checkOutput("relock", 32'(locked), 32'd1);

    // Timeout: hsync held high well past the 2047-clock saturation point.
    applyStimulus(8'hFF, 1'b0, 1'b1);
    waitHold(1700);
    checkOutput("holdStillLocked", 32'(locked), 32'd1);
    waitHold(2150);
    checkOutput("timeoutLocked", 32'(locked), 32'd0);
    checkOutput("timeoutR", 32'(vga_r), 32'd0);
    baseR = frameNo + 1;
    applyStimulus(8'hFF, 1'b0, 1'b0);
    waitFrame(baseR);
    waitPos(1, 50);
    checkOutput("resumeHperiod", 32'(hperiod), 32'd192);
    waitFrame(baseR + 3);
    waitClocks(4);
    checkOutput("timeoutRelockEarly", 32'(locked), 32'd0);
    waitFrame(baseR + 4);
    waitClocks(4);
    checkOutput("timeoutRelock", 32'(locked), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
